psum_requant: RTL and testbench

Output requantization stage sitting directly downstream of the MAC accumulation chain. Consumes finished 32-bit signed partial sums, adds a per-layer bias, scales by a fixed-point multiplier with rounding right shift, applies optional ReLU, and saturates to INT8 for write-back to the activation buffer. It is a 3-stage pipeline with valid/ready flow control.

---
 rtl/psum_requant.sv | 131 +++++++++++++
 tb/tb_psum_requant.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_requant.sv
// Requantization stage after the MAC chain: bias add, fixed-point scale with
// rounding shift, optional ReLU and INT8 saturation, as a 3-stage valid/ready pipeline.
`timescale 1ns/1ps
module psum_requant #(
  parameter int PSUM_W  = 32,
  parameter int SCALE_W = 16,
  parameter int OUT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_load,
  input  logic signed [PSUM_W-1:0]  cfg_bias,
  input  logic signed [SCALE_W-1:0] cfg_scale,
  input  logic [5:0]                cfg_shift,
  input  logic                      cfg_relu,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [PSUM_W-1:0]  psum_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   q_out,
  output logic                      busy
);

  localparam int PROD_W = PSUM_W + SCALE_W;
  // One extra bit so adding the rounding constant can never wrap.
  localparam int RND_W  = PROD_W + 1;

  localparam logic signed [PSUM_W-1:0] PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic signed [PSUM_W-1:0] PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};
  localparam logic signed [RND_W-1:0]  WIDE_MAX = {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0]  WIDE_MIN = {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0]  Q_MAX    = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0]  Q_MIN    = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [PSUM_W-1:0]  bias_q;
  logic signed [SCALE_W-1:0] scale_q;
  logic [5:0]                shift_q;
  logic                      relu_q;

  logic                      v1_q, v2_q, v3_q;
  logic signed [PSUM_W-1:0]  s1_q, s1_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic signed [OUT_W-1:0]   q_q, q_d;

  logic                      en;
  logic                      accept;
  logic                      cfgWe;
  logic [5:0]                shiftClamped;
  logic signed [PSUM_W:0]    sumWide;
  logic [RND_W-1:0]          rndBit;
  logic signed [RND_W-1:0]   rounded;
  logic signed [RND_W-1:0]   shifted;
  logic signed [RND_W-1:0]   clipped;

  assign busy      = v1_q | v2_q | v3_q;
  assign en        = !v3_q || out_ready;
  assign in_ready  = en;
  assign accept    = in_valid && en;
  assign out_valid = v3_q;
  assign q_out     = q_q;

  // Config may only change with an empty pipeline and no sample being offered.
  assign cfgWe        = cfg_load && !busy && !in_valid;
  assign shiftClamped = (cfg_shift > 6'd47) ? 6'd47 : cfg_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_q  <= '0;
      scale_q <= {{(SCALE_W-1){1'b0}}, 1'b1};
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (cfgWe) begin
      bias_q  <= cfg_bias;
      scale_q <= cfg_scale;
      shift_q <= shiftClamped;
      relu_q  <= cfg_relu;
    end
  end

  assign sumWide = {psum_in[PSUM_W-1], psum_in} + {bias_q[PSUM_W-1], bias_q};

  always_comb begin
    s1_d = sumWide[PSUM_W-1:0];
    if (sumWide[PSUM_W] != sumWide[PSUM_W-1]) begin
      s1_d = sumWide[PSUM_W] ? PSUM_MIN : PSUM_MAX;
    end
  end

  assign prod_d = PROD_W'(s1_q) * PROD_W'(scale_q);

  always_comb begin
    rndBit = '0;
    if (shift_q != 6'd0) begin
      rndBit[shift_q - 6'd1] = 1'b1;
    end
  end

  assign rounded = $signed({prod_q[PROD_W-1], prod_q}) + $signed(rndBit);
  assign shifted = rounded >>> shift_q;
  assign clipped = (relu_q && shifted[RND_W-1]) ? '0 : shifted;

  always_comb begin
    q_d = clipped[OUT_W-1:0];
    if (clipped > WIDE_MAX) begin
      q_d = Q_MAX;
    end else if (clipped < WIDE_MIN) begin
      q_d = Q_MIN;
    end
  end

  // All stages advance together; bubbles travel with their valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      s1_q   <= '0;
      prod_q <= '0;
      q_q    <= '0;
    end else if (en) begin
      v1_q   <= accept;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      s1_q   <= s1_d;
      prod_q <= prod_d;
      q_q    <= q_d;
    end
  end

endmodule

// File: tb/tb_psum_requant.sv
// Scoreboard bench for psum_requant: directed vectors push expected INT8 results
// on accept; a negedge monitor pops and compares on every output transfer.
`timescale 1ns/1ps
module tb_psum_requant;

  logic               clk;
  logic               rst;
  logic               cfg_load;
  logic signed [31:0] cfg_bias;
  logic signed [15:0] cfg_scale;
  logic [5:0]         cfg_shift;
  logic               cfg_relu;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] psum_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  q_out;
  logic               busy;

  psum_requant #(.PSUM_W(32), .SCALE_W(16), .OUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load), .cfg_bias(cfg_bias), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(in_ready), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready), .q_out(q_out),
    .busy(busy)
  );

  typedef struct {
    logic signed [7:0] val;
    int                accCycle;
    bit                chkLat;
  } exp_t;

  exp_t              sb[$];
  exp_t              popped;
  int                checks = 0;
  int                errors = 0;
  int                cycle = 0;
  int                acceptCount = 0;
  bit                holdArmed = 0;
  logic signed [7:0] holdVal;
  int                acceptBase;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input longint actual, input longint required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Monitor: compares every transfer against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      holdArmed = 0;
    end else begin
      if (holdArmed) begin
        checks++;
        if (!out_valid || q_out !== holdVal) begin
          errors++;
          $display("[TB] FAIL hold: out_valid=%0b q_out=%0d, required 1/%0d", out_valid, q_out, holdVal);
        end
      end
      holdArmed = out_valid && !out_ready;
      holdVal   = q_out;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_output: got q_out=%0d, required no output", q_out);
        end else begin
          popped = sb.pop_front();
          if (q_out !== popped.val) begin
            errors++;
            $display("[TB] FAIL q_out: got %0d, required %0d", q_out, popped.val);
          end
          if (popped.chkLat) begin
            checks++;
            if (cycle - popped.accCycle != 3) begin
              errors++;
              $display("[TB] FAIL latency: got %0d cycles, required 3", cycle - popped.accCycle);
            end
          end
        end
      end
    end
  end

  // Offers one sample; called and returns just after a rising edge with in_valid still high.
  task automatic applyStimulus(input logic signed [31:0] psum, input logic signed [7:0] expVal,
                               input bit chkLat);
    bit   accepted;
    exp_t e;
    accepted = 0;
    in_valid = 1'b1;
    psum_in  = psum;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.val      = expVal;
        e.accCycle = cycle;
        e.chkLat   = chkLat;
        sb.push_back(e);
        acceptCount++;
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept for psum %0d, required accept", psum);
    end
  endtask

  task automatic idleInput();
    in_valid = 1'b0;
    psum_in  = '0;
  endtask

  task automatic loadCfg(input logic signed [31:0] b, input logic signed [15:0] s,
                         input logic [5:0] sh, input logic r);
    cfg_bias  = b;
    cfg_scale = s;
    cfg_shift = sh;
    cfg_relu  = r;
    cfg_load  = 1'b1;
    @(posedge clk);
    #1;
    cfg_load  = 1'b0;
  endtask

  task automatic waitDrain();
    bit drained;
    drained = 0;
    for (int i = 0; i < 200 && !drained; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) drained = 1;
    end
    if (!drained) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cfg_load = 1'b0; cfg_bias = '0; cfg_scale = 16'sd1; cfg_shift = '0; cfg_relu = 1'b0;
    in_valid = 1'b0; psum_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_q_out", q_out, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Default config: identity plus saturation, back-to-back with latency check.
    applyStimulus(100, 100, 1);
    applyStimulus(300, 127, 1);
    applyStimulus(-500, -128, 1);
    idleInput();
    waitDrain();

    loadCfg(10, 3, 2, 0);
    applyStimulus(50, 45, 1);
    idleInput();
    waitDrain();

    loadCfg(0, 1, 2, 0);
    applyStimulus(-10, -2, 1);
    applyStimulus(-6, -1, 1);
    applyStimulus(6, 2, 1);
    idleInput();
    waitDrain();

    loadCfg(0, -2, 0, 0);
    applyStimulus(20, -40, 1);
    idleInput();
    waitDrain();

    // Bias saturation at S1, made visible through large shifts.
    loadCfg(1, 1, 0, 0);
    applyStimulus(32'sh7FFFFFFF, 127, 1);
    idleInput();
    waitDrain();
    loadCfg(1, 1, 31, 0);
    applyStimulus(32'sh7FFFFFFF, 1, 1);
    idleInput();
    waitDrain();
    loadCfg(1, 1, 32, 0);
    applyStimulus(32'sh7FFFFFFF, 0, 1);
    idleInput();
    waitDrain();
    loadCfg(-1, 1, 31, 0);
    applyStimulus(32'sh80000000, -1, 1);
    idleInput();
    waitDrain();
    loadCfg(0, 16'sd32767, 6'd63, 0);
    applyStimulus(32'sh80000000, 0, 1);
    idleInput();
    waitDrain();

    loadCfg(0, 1, 0, 1);
    applyStimulus(-50, 0, 1);
    applyStimulus(50, 50, 1);
    applyStimulus(1000, 127, 1);
    idleInput();
    waitDrain();

    // Load while busy is ignored; the same load after drain takes effect.
    loadCfg(0, 1, 0, 0);
    applyStimulus(10, 10, 1);
    idleInput();
    loadCfg(0, 5, 0, 0);
    waitDrain();
    applyStimulus(10, 10, 1);
    idleInput();
    waitDrain();
    loadCfg(0, 5, 0, 0);
    applyStimulus(10, 50, 1);
    idleInput();
    waitDrain();

    // Load coinciding with in_valid is ignored.
    cfg_bias = 0; cfg_scale = 7; cfg_shift = 0; cfg_relu = 0; cfg_load = 1'b1;
    applyStimulus(3, 15, 1);
    cfg_load = 1'b0;
    idleInput();
    waitDrain();
    applyStimulus(3, 15, 1);
    idleInput();
    waitDrain();

    // Backpressure: five offered, three fit, rest follow once out_ready rises.
    loadCfg(0, 1, 0, 0);
    out_ready  = 1'b0;
    acceptBase = acceptCount;
    fork
      begin
        for (int k = 1; k <= 5; k++) applyStimulus(k, 8'(k), 0);
        idleInput();
      end
    join_none
    repeat (6) @(negedge clk);
    checkOutput("bp_accepted", acceptCount - acceptBase, 3);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_q_out_head", q_out, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("bp_total_accepted", acceptCount - acceptBase, 5);

    // Reset with three samples in flight discards them.
    loadCfg(5, 1, 0, 0);
    out_ready = 1'b0;
    applyStimulus(1, 6, 0);
    applyStimulus(2, 7, 0);
    applyStimulus(3, 8, 0);
    idleInput();
    checkOutput("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_q_out", q_out, 0);
    checkOutput("midreset_busy", busy, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("post_reset_out_valid", out_valid, 0);
    applyStimulus(100, 100, 1);
    idleInput();
    waitDrain();

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
